// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
//   Single-neuron multiply-accumulate sequencer. Walks the weight ROM
//   (zero-latency combinational read), multiplies each weight against an
//   incoming activation, adds the bias, then rescales, saturates and
//   optionally ReLU-clamps the sum into a Q-format result.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin one evaluation (honoured in IDLE only)
//   busy              high from accepted start until the output handshake
//   x_in/x_valid/     signed activation stream; a pair is consumed on
//   x_ready             x_valid && x_ready
//   wt_addr/wt_in     ROM read address and same-cycle signed weight/bias
//   y_out/y_valid/    signed result, held stable until y_ready
//   y_ready
// -----------------------------------------------------------------------------
module neuron_mac #(
  parameter int N_IN    = 5,
  parameter int WT_BASE = 0,
  parameter int FRAC    = 8,
  parameter int ACC_W   = 40,
  parameter int RELU    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  input  logic [15:0] x_in,
  input  logic        x_valid,
  output logic        x_ready,
  output logic [3:0]  wt_addr,
  input  logic [15:0] wt_in,
  output logic [15:0] y_out,
  output logic        y_valid,
  input  logic        y_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_BIAS,
    S_SAT,
    S_OUT
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-32768);

  state_e                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     busy_q, busy_d;
  logic                     y_valid_q, y_valid_d;
  logic [15:0]              y_out_q, y_out_d;

  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  acc_scaled;
  logic [15:0]              y_sat;

  // Full-precision product; the accumulator is wide enough that it never wraps.
  assign prod     = $signed(x_in) * $signed(wt_in);
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  // Bias is stored in the same Q-format as the output, so it is lifted to the
  // product's 2*FRAC fractional scale before being added.
  assign bias_ext = $signed({{(ACC_W-16){wt_in[15]}}, wt_in}) <<< FRAC;
  // Arithmetic shift rounds toward -inf, returning to FRAC fractional bits.
  assign acc_scaled = acc_q >>> FRAC;

  always_comb begin
    if (acc_scaled > Y_MAX)      y_sat = 16'h7FFF;
    else if (acc_scaled < Y_MIN) y_sat = 16'h8000;
    else                         y_sat = acc_scaled[15:0];
    if ((RELU != 0) && y_sat[15]) y_sat = 16'h0000;
  end

  // ROM address and activation ready are decoded straight from state/idx so
  // the ROM data lines up with the activation in the same cycle.
  always_comb begin
    wt_addr = 4'(WT_BASE);
    x_ready = 1'b0;
    unique case (state_q)
      S_ACCUM: begin
        wt_addr = 4'(WT_BASE) + idx_q;
        x_ready = 1'b1;
      end
      S_BIAS:  wt_addr = 4'(WT_BASE + N_IN);
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case
    // leaves a variable unassigned and no latch can be inferred.
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    y_out_d   = y_out_q;
    y_valid_d = y_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (x_valid && x_ready) begin
          acc_d = acc_q + prod_ext;
          idx_d = idx_q + 4'd1;
          if (idx_q == LAST_IDX) state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        acc_d   = acc_q + bias_ext;
        state_d = S_SAT;
      end
      S_SAT: begin
        y_out_d   = y_sat;
        y_valid_d = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        // A start arriving with the handshake is dropped: the FSM is not in IDLE.
        if (y_ready) begin
          y_valid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign busy    = busy_q;
  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

  // Weights plus bias must fit the 4-bit ROM address space, and the
  // accumulator must be wide enough to hold N_IN products plus the bias.
  cfg_check_a : assert property (@(posedge clk)
      ((WT_BASE + N_IN) <= 15) && (ACC_W >= 32 + $clog2(N_IN + 1)))
    else $error("neuron_mac: illegal WT_BASE/N_IN/ACC_W configuration");

endmodule

// File: tb/tb_neuron_mac.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac
//   Two neuron_mac instances (RELU=1 and RELU=0) share one stimulus stream and
//   one bench-side weight ROM. A driver pushes reference results into per-DUT
//   queues; an independent monitor pops and compares on each output handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_neuron_mac;
  localparam int N_IN    = 5;
  localparam int WT_BASE = 0;
  localparam int FRAC    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        x_valid = 1'b0;
  logic        y_ready = 1'b0;
  logic [15:0] x_in = '0;

  logic        busy1, x_ready1, y_valid1;
  logic [3:0]  wt_addr1;
  logic [15:0] wt_in1, y_out1;
  logic        busy0, x_ready0, y_valid0;
  logic [3:0]  wt_addr0;
  logic [15:0] wt_in0, y_out0;

  logic [15:0] rom   [16];
  logic [15:0] cur_x [N_IN];

  assign wt_in1 = rom[wt_addr1];
  assign wt_in0 = rom[wt_addr0];

  neuron_mac #(.N_IN(N_IN), .WT_BASE(WT_BASE), .FRAC(FRAC), .ACC_W(40), .RELU(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready1),
    .wt_addr(wt_addr1), .wt_in(wt_in1),
    .y_out(y_out1), .y_valid(y_valid1), .y_ready(y_ready)
  );

  neuron_mac #(.N_IN(N_IN), .WT_BASE(WT_BASE), .FRAC(FRAC), .ACC_W(40), .RELU(0)) dut_lin (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0),
    .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready0),
    .wt_addr(wt_addr0), .wt_in(wt_in0),
    .y_out(y_out0), .y_valid(y_valid0), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_exp = 0;
  int n_out1 = 0;
  int n_out0 = 0;
  logic [15:0] q1 [$];
  logic [15:0] q0 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: plain dot product in wide integers, floor-rescale, clamp, ReLU.
  function automatic logic [15:0] ref_y(input bit relu);
    longint s = 0;
    longint r;
    for (int i = 0; i < N_IN; i++)
      s += longint'($signed(cur_x[i])) * longint'($signed(rom[WT_BASE + i]));
    s += longint'($signed(rom[WT_BASE + N_IN])) * (longint'(1) << FRAC);
    r = s >>> FRAC;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  function automatic logic [15:0] rnd16();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 2047)) - 16'd1024;
  endfunction

  // Monitor: compare whenever a handshake is about to complete on the next edge.
  always @(negedge clk) begin
    if (rst_n && y_valid1 && y_ready) begin
      n_out1++;
      if (q1.size() == 0) fail_now("y_relu1 unexpected output");
      else check("y_relu1", 32'(y_out1), 32'(q1.pop_front()));
    end
    if (rst_n && y_valid0 && y_ready) begin
      n_out0++;
      if (q0.size() == 0) fail_now("y_relu0 unexpected output");
      else check("y_relu0", 32'(y_out0), 32'(q0.pop_front()));
    end
  end

  task automatic set_basic();
    for (int i = 0; i < 16; i++) rom[i] = '0;
    rom[WT_BASE+0] = 16'h0100; rom[WT_BASE+1] = 16'h0200; rom[WT_BASE+2] = 16'hFF00;
    rom[WT_BASE+3] = 16'h0080; rom[WT_BASE+4] = 16'h0000; rom[WT_BASE+5] = 16'h0100;
    cur_x = '{16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h7FFF};
  endtask

  // One full evaluation. gaps: x_valid pattern 1,0,0 repeating plus start
  // pulses during ACCUM and OUT. yr_delay: cycles y_ready stays low after y_valid.
  task automatic run_neuron(input bit gaps, input int yr_delay, input bit chk_lat);
    int k;
    int t;
    int start_cyc;
    logic acc_ok;
    logic [15:0] held;
    q1.push_back(ref_y(1'b1));
    q0.push_back(ref_y(1'b0));
    n_exp++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", 32'(busy1), 32'd1);
    k = 0;
    t = 0;
    while (k < N_IN && t < 200) begin
      x_valid = gaps ? (t % 3 == 0) : 1'b1;
      x_in    = cur_x[k];
      start   = gaps && (t == 2);
      @(negedge clk);
      check("x_ready_accum", 32'(x_ready1), 32'd1);
      check("wt_addr_accum", 32'(wt_addr1), 32'(WT_BASE + k));
      acc_ok = x_valid && x_ready1;
      @(posedge clk); #1;
      if (acc_ok) k++;
      t++;
    end
    start   = 1'b0;
    x_valid = 1'b0;
    if (k != N_IN) begin
      fail_now("accum timeout");
      return;
    end
    @(negedge clk);
    check("wt_addr_bias", 32'(wt_addr1), 32'(WT_BASE + N_IN));
    check("x_ready_bias", 32'(x_ready0), 32'd0);
    t = 0;
    while (!y_valid1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!y_valid1) begin
      fail_now("y_valid timeout");
      return;
    end
    if (chk_lat) check("latency", 32'(cyc - start_cyc), 32'd7);
    held = y_out1;
    for (int i = 0; i < yr_delay; i++) begin
      @(posedge clk); #1;
      check("y_out_stable", 32'(y_out1), 32'(held));
      check("y_valid_held", 32'(y_valid1), 32'd1);
      check("busy_held", 32'(busy1), 32'd1);
    end
    y_ready = 1'b1;
    start   = gaps;
    @(posedge clk); #1;
    y_ready = 1'b0;
    start   = 1'b0;
    check("y_valid_dropped", 32'(y_valid1), 32'd0);
    check("busy_dropped", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    check("no_restart", 32'(busy1), 32'd0);
  endtask

  task automatic run_reset_mid();
    int k = 0;
    int t = 0;
    logic acc_ok;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < 2 && t < 50) begin
      x_valid = 1'b1;
      x_in    = cur_x[k];
      @(negedge clk);
      acc_ok = x_valid && x_ready1;
      @(posedge clk); #1;
      if (acc_ok) k++;
      t++;
    end
    x_valid = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_busy", 32'(busy1), 32'd0);
    check("rst_mid_x_ready", 32'(x_ready1), 32'd0);
    check("rst_mid_wt_addr", 32'(wt_addr1), 32'(WT_BASE));
    check("rst_mid_y_out", 32'(y_out1), 32'd0);
    check("rst_mid_y_valid", 32'(y_valid1), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    set_basic();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_x_ready", 32'(x_ready1), 32'd0);
    check("rst_wt_addr", 32'(wt_addr1), 32'(WT_BASE));
    check("rst_y_out", 32'(y_out1), 32'd0);
    check("rst_y_valid", 32'(y_valid1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic dot product: 1+2-1+1+0 + bias 1 = 4.0
    set_basic();
    if (ref_y(1'b1) !== 16'h0400) fail_now("model basic");
    run_neuron(1'b0, 0, 1'b1);

    // Negative result: -10 + 1 = -9
    set_basic();
    cur_x = '{16'h0000, 16'h0000, 16'h0A00, 16'h0000, 16'h0000};
    run_neuron(1'b0, 0, 1'b1);

    // Positive saturation, then negative saturation
    for (int i = 0; i <= N_IN; i++) rom[WT_BASE + i] = 16'h7FFF;
    for (int i = 0; i < N_IN; i++) cur_x[i] = 16'h7FFF;
    run_neuron(1'b0, 0, 1'b1);
    for (int i = 0; i <= N_IN; i++) rom[WT_BASE + i] = 16'h8001;
    run_neuron(1'b0, 0, 1'b1);

    // Backpressure on both sides with ignored start pulses
    set_basic();
    run_neuron(1'b1, 5, 1'b0);

    // Reset mid-ACCUM, then a clean rerun
    set_basic();
    run_reset_mid();
    run_neuron(1'b0, 0, 1'b1);

    // Randomized evaluations
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i <= N_IN; i++) rom[WT_BASE + i] = rnd16();
      for (int i = 0; i < N_IN; i++) cur_x[i] = rnd16();
      run_neuron(1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("out_count_relu1", 32'(n_out1), 32'(n_exp));
    check("out_count_relu0", 32'(n_out0), 32'(n_exp));
    check("queue_empty_relu1", 32'(q1.size()), 32'd0);
    check("queue_empty_relu0", 32'(q0.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
